// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and counter-width helper for pll_reset_sequencer
package pll_seq_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with asynchronous active-high clear
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta_q} <= 2'b00;
    else     {q, meta_q} <= {meta_q, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock, then releases per-domain resets in staged order.
// Optional HEARTBEAT_EN adds a heartbeat output toggling every HB_DIV cycles while in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGES        = 3,
  parameter int STAGE_GAP     = 16,
  parameter int CNT_W         = 8,
  parameter int HB_DIV        = 50000000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic [CNT_W-1:0]  lock_loss_cnt
`ifdef HEARTBEAT_EN
  ,
  output logic              heartbeat
`endif
);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int GW = cnt_w(STAGE_GAP);
  if (STABLE_CYCLES < 2 || STAGES < 1 || STAGES > 8 || STAGE_GAP < 1 || HB_DIV < 1) begin : g_bad_cfg
    $error("pll_reset_sequencer: illegal parameter set");
  end
  logic              locked_s, lost;
  state_e            state_q, state_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [3:0]        stage_q, stage_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic [STAGES-1:0] rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  sync_2ff u_sync (.clk(sys_clk), .rst(rst), .d(pll_locked), .q(locked_s));
  assign lost = !locked_s && (state_q == RELEASE || state_q == RUN);
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state_q   <= WAIT_LOCK;
      stable_q  <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
      loss_q    <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      gap_q     <= gap_d;
      stage_q   <= stage_d;
      loss_q    <= loss_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    gap_d    = gap_q;
    stage_d  = stage_q;
    loss_d   = (lost && loss_q != '1) ? loss_q + 1'b1 : loss_q;
    case (state_q)
      WAIT_LOCK: begin
        stable_d = '0;
        state_d  = locked_s ? STABLE : WAIT_LOCK;
      end
      STABLE: begin
        stable_d = locked_s ? stable_q + 1'b1 : '0;
        gap_d    = '0;
        stage_d  = '0;
        state_d  = !locked_s ? WAIT_LOCK :
                   (stable_q == SW'(STABLE_CYCLES - 1)) ? RELEASE : STABLE;
      end
      RELEASE: begin
        // one stage drops each time the gap counter reaches zero; the final zero enters RUN
        state_d = !locked_s ? WAIT_LOCK :
                  (gap_q == '0 && stage_q == 4'(STAGES)) ? RUN : RELEASE;
        gap_d   = (gap_q != '0) ? gap_q - 1'b1 : GW'(STAGE_GAP - 1);
        stage_d = (gap_q == '0 && stage_q != 4'(STAGES)) ? stage_q + 1'b1 : stage_q;
      end
      default: state_d = locked_s ? RUN : WAIT_LOCK;
    endcase
  end
  always_comb begin
    ready_d   = state_d == RUN;
    rst_out_d = '1;
    for (int k = 0; k < STAGES; k++)
      rst_out_d[k] = !(state_d == RUN || (state_d == RELEASE && 4'(k) < stage_d));
  end
  assign rst_out       = rst_out_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
`ifdef HEARTBEAT_EN
  localparam int HW = cnt_w(HB_DIV);
  logic [HW-1:0] hb_cnt_q, hb_cnt_d;
  logic          hb_q, hb_d, hb_run, hb_wrap;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  always_comb begin
    hb_run   = state_q == RUN && state_d == RUN;
    hb_wrap  = hb_cnt_q == HW'(HB_DIV - 1);
    hb_cnt_d = (hb_run && !hb_wrap) ? hb_cnt_q + 1'b1 : '0;
    hb_d     = hb_run && (hb_q ^ hb_wrap);
  end
  assign heartbeat = hb_q;
`endif
endmodule
